wb_ctrl: RTL and testbench

//  Writeback/return path of the milano pipeline: the counterpart to the forward ID->EX register stage.

---
 rtl/milano_pkg.sv | 24 ++
 rtl/wb_ctrl_if.sv | 53 +++++
 rtl/wb_scoreboard.sv | 75 +++++++
 rtl/wb_ctrl.sv | 120 ++++++++++++
 tb/tb_wb_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/milano_pkg.sv
// Shared types and constants for the milano pipeline writeback path.
package milano_pkg;

    localparam int XLEN       = 32;
    localparam int LOAD_CNT_W = 3;

    typedef logic [4:0]            reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [LOAD_CNT_W-1:0] load_cnt_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_EX   = 2'd1,
        WB_SRC_LSU  = 2'd2
    } wb_src_e;

    // x0 is hardwired to zero, so nothing targeting it is ever tracked or written.
    function automatic logic writes_reg(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Bundle of ID issue, EX result, LSU response, regfile write and forwarding signals around wb_ctrl.
interface wb_ctrl_if;
    import milano_pkg::*;

    logic      issue_valid_i;
    reg_addr_t issue_rd_addr_i;
    logic      issue_rd_we_i;
    logic      issue_is_load_i;
    reg_addr_t rs1_addr_i;
    reg_addr_t rs2_addr_i;
    logic [1:0] rs_use_i;
    logic      stall_id_o;

    logic      ex_valid_i;
    reg_addr_t ex_rd_addr_i;
    logic      ex_rd_we_i;
    xlen_t     ex_result_i;

    logic      lsu_rvalid_i;
    logic      lsu_rready_o;
    reg_addr_t lsu_rd_addr_i;
    xlen_t     lsu_rdata_i;

    logic      rf_we_o;
    reg_addr_t rf_waddr_o;
    xlen_t     rf_wdata_o;

    logic      fwd_rs1_o;
    logic      fwd_rs2_o;
    xlen_t     fwd_rs1_data_o;
    xlen_t     fwd_rs2_data_o;

    modport master (
        output issue_valid_i, issue_rd_addr_i, issue_rd_we_i, issue_is_load_i,
        output rs1_addr_i, rs2_addr_i, rs_use_i,
        output ex_valid_i, ex_rd_addr_i, ex_rd_we_i, ex_result_i,
        output lsu_rvalid_i, lsu_rd_addr_i, lsu_rdata_i,
        input  stall_id_o, lsu_rready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  fwd_rs1_o, fwd_rs2_o, fwd_rs1_data_o, fwd_rs2_data_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_addr_i, issue_rd_we_i, issue_is_load_i,
        input  rs1_addr_i, rs2_addr_i, rs_use_i,
        input  ex_valid_i, ex_rd_addr_i, ex_rd_we_i, ex_result_i,
        input  lsu_rvalid_i, lsu_rd_addr_i, lsu_rdata_i,
        output stall_id_o, lsu_rready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output fwd_rs1_o, fwd_rs2_o, fwd_rs1_data_o, fwd_rs2_data_o
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy bit per architectural register with a pending load, plus the outstanding-load counter.
module wb_scoreboard
    import milano_pkg::*;
#(
    parameter int MAX_LOADS = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      set_i,
    input  reg_addr_t set_addr_i,
    input  logic      clr_i,
    input  reg_addr_t clr_addr_i,
    input  logic      load_issue_i,
    input  logic      load_done_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    input  reg_addr_t rd_addr_i,
    output logic      rs1_busy_o,
    output logic      rs2_busy_o,
    output logic      rd_busy_o,
    output logic      loads_full_o
);

    localparam load_cnt_t MAX_CNT = load_cnt_t'(MAX_LOADS);

    logic [31:0] busy_q;
    logic [31:0] busy_d;
    load_cnt_t   count_q;
    load_cnt_t   count_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Simultaneous issue and completion leave the count unchanged; the guards only stop wrap.
    always_comb begin
        count_d = count_q;
        case ({load_issue_i, load_done_i})
            2'b10: begin
                if (count_q != MAX_CNT) begin
                    count_d = count_q + load_cnt_t'(1);
                end
            end
            2'b01: begin
                if (count_q != '0) begin
                    count_d = count_q - load_cnt_t'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign rs1_busy_o   = busy_q[rs1_addr_i];
    assign rs2_busy_o   = busy_q[rs2_addr_i];
    assign rd_busy_o    = busy_q[rd_addr_i];
    assign loads_full_o = (count_q == MAX_CNT);

endmodule

// File: rtl/wb_ctrl.sv
// Writeback stage: arbitrates the single regfile write port between EX and LSU,
// drives ID hazard stalls from the load scoreboard and forwards the registered write.
module wb_ctrl
    import milano_pkg::*;
#(
    parameter int MAX_LOADS = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    wb_ctrl_if.slave   bus
);

    logic      ex_wr;
    logic      lsu_accept;
    logic      issue_accept;
    logic      load_set;
    logic      load_issue;
    logic      stall;
    wb_src_e   wb_src;

    logic      rs1_busy;
    logic      rs2_busy;
    logic      rd_busy;
    logic      loads_full;

    logic      rf_we_q;
    logic      rf_we_d;
    reg_addr_t rf_waddr_q;
    reg_addr_t rf_waddr_d;
    xlen_t     rf_wdata_q;
    xlen_t     rf_wdata_d;

    // EX cannot be stalled, so it always wins the port; the LSU waits for a free cycle.
    always_comb begin
        ex_wr      = bus.ex_valid_i && bus.ex_rd_we_i && writes_reg(bus.ex_rd_addr_i);
        lsu_accept = bus.lsu_rvalid_i && !ex_wr;
        wb_src     = WB_SRC_NONE;
        if (ex_wr) begin
            wb_src = WB_SRC_EX;
        end else if (lsu_accept && writes_reg(bus.lsu_rd_addr_i)) begin
            wb_src = WB_SRC_LSU;
        end
    end

    // The last term injects bubbles while a load response is blocked so EX eventually frees the port.
    always_comb begin
        stall = (bus.rs_use_i[0] && rs1_busy)
             || (bus.rs_use_i[1] && rs2_busy)
             || (bus.issue_rd_we_i && rd_busy)
             || (bus.issue_is_load_i && loads_full)
             || (bus.lsu_rvalid_i && ex_wr);
        issue_accept = bus.issue_valid_i && !stall;
        load_issue   = issue_accept && bus.issue_is_load_i;
        load_set     = load_issue && bus.issue_rd_we_i && writes_reg(bus.issue_rd_addr_i);
    end

    wb_scoreboard #(
        .MAX_LOADS (MAX_LOADS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .set_i        (load_set),
        .set_addr_i   (bus.issue_rd_addr_i),
        .clr_i        (lsu_accept),
        .clr_addr_i   (bus.lsu_rd_addr_i),
        .load_issue_i (load_issue),
        .load_done_i  (lsu_accept),
        .rs1_addr_i   (bus.rs1_addr_i),
        .rs2_addr_i   (bus.rs2_addr_i),
        .rd_addr_i    (bus.issue_rd_addr_i),
        .rs1_busy_o   (rs1_busy),
        .rs2_busy_o   (rs2_busy),
        .rd_busy_o    (rd_busy),
        .loads_full_o (loads_full)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (wb_src)
            WB_SRC_EX: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.ex_rd_addr_i;
                rf_wdata_d = bus.ex_result_i;
            end
            WB_SRC_LSU: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.lsu_rd_addr_i;
                rf_wdata_d = bus.lsu_rdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= REG_ZERO;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.stall_id_o   = stall;
    assign bus.lsu_rready_o = !ex_wr;
    assign bus.rf_we_o      = rf_we_q;
    assign bus.rf_waddr_o   = rf_waddr_q;
    assign bus.rf_wdata_o   = rf_wdata_q;

    // The regfile only sees the write on the next edge, so ID reads the in-flight value from here.
    assign bus.fwd_rs1_o      = rf_we_q && (rf_waddr_q == bus.rs1_addr_i) && writes_reg(bus.rs1_addr_i);
    assign bus.fwd_rs2_o      = rf_we_q && (rf_waddr_q == bus.rs2_addr_i) && writes_reg(bus.rs2_addr_i);
    assign bus.fwd_rs1_data_o = rf_wdata_q;
    assign bus.fwd_rs2_data_o = rf_wdata_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: per-cycle vector table with expected writes queued and
// popped after the edge, plus hand sequences for load limit and reset during a pending load.
module tb_wb_ctrl;
    import milano_pkg::*;

    typedef struct {
        logic       iv;
        reg_addr_t  ird;
        logic       ild;
        reg_addr_t  rs1;
        reg_addr_t  rs2;
        logic [1:0] rsu;
        logic       exv;
        reg_addr_t  exrd;
        xlen_t      exd;
        logic       lv;
        reg_addr_t  lrd;
        xlen_t      ld;
        logic       st;
        logic       rr;
        logic       f1;
        logic       f2;
        logic       we;
        reg_addr_t  wa;
        xlen_t      wd;
    } vec_t;

    typedef struct {
        logic      we;
        reg_addr_t wa;
        xlen_t     wd;
    } wr_t;

    logic  clk;
    logic  rst_n;
    int    checks;
    int    errors;
    xlen_t last_wd;
    wr_t   exp_q[$];
    vec_t  tbl[$];
    vec_t  seq_max[$];
    vec_t  seq_rst[$];
    vec_t  tv;

    wb_ctrl_if bus();

    wb_ctrl #(
        .MAX_LOADS (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input xlen_t act, input xlen_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_flag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.issue_valid_i   = 1'b0;
        bus.issue_rd_addr_i = REG_ZERO;
        bus.issue_rd_we_i   = 1'b0;
        bus.issue_is_load_i = 1'b0;
        bus.rs1_addr_i      = REG_ZERO;
        bus.rs2_addr_i      = REG_ZERO;
        bus.rs_use_i        = 2'b00;
        bus.ex_valid_i      = 1'b0;
        bus.ex_rd_addr_i    = REG_ZERO;
        bus.ex_rd_we_i      = 1'b0;
        bus.ex_result_i     = '0;
        bus.lsu_rvalid_i    = 1'b0;
        bus.lsu_rd_addr_i   = REG_ZERO;
        bus.lsu_rdata_i     = '0;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        wr_t w;
        @(negedge clk);
        bus.issue_valid_i   = v.iv;
        bus.issue_rd_addr_i = v.ird;
        bus.issue_rd_we_i   = v.iv;
        bus.issue_is_load_i = v.ild;
        bus.rs1_addr_i      = v.rs1;
        bus.rs2_addr_i      = v.rs2;
        bus.rs_use_i        = v.rsu;
        bus.ex_valid_i      = v.exv;
        bus.ex_rd_addr_i    = v.exrd;
        bus.ex_rd_we_i      = v.exv;
        bus.ex_result_i     = v.exd;
        bus.lsu_rvalid_i    = v.lv;
        bus.lsu_rd_addr_i   = v.lrd;
        bus.lsu_rdata_i     = v.ld;
        #1;
        check_flag({tag, ".stall"}, bus.stall_id_o, v.st);
        check_flag({tag, ".rready"}, bus.lsu_rready_o, v.rr);
        check_flag({tag, ".fwd1"}, bus.fwd_rs1_o, v.f1);
        check_flag({tag, ".fwd2"}, bus.fwd_rs2_o, v.f2);
        if (v.f1) check_output({tag, ".fwd1_data"}, bus.fwd_rs1_data_o, last_wd);
        if (v.f2) check_output({tag, ".fwd2_data"}, bus.fwd_rs2_data_o, last_wd);
        exp_q.push_back('{v.we, v.wa, v.wd});
        @(posedge clk);
        #1;
        w = exp_q.pop_front();
        check_flag({tag, ".rf_we"}, bus.rf_we_o, w.we);
        check_output({tag, ".rf_waddr"}, 32'(bus.rf_waddr_o), 32'(w.wa));
        check_output({tag, ".rf_wdata"}, bus.rf_wdata_o, w.wd);
        last_wd = w.wd;
    endtask

    task automatic check_reset_state(input string tag);
        check_flag({tag, ".rf_we"}, bus.rf_we_o, 1'b0);
        check_output({tag, ".rf_waddr"}, 32'(bus.rf_waddr_o), 32'h0);
        check_output({tag, ".rf_wdata"}, bus.rf_wdata_o, 32'h0);
        check_flag({tag, ".stall"}, bus.stall_id_o, 1'b0);
        check_flag({tag, ".rready"}, bus.lsu_rready_o, 1'b1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_wd = '0;
        rst_n   = 1'b0;
        drive_idle();

        // Fields: iv,ird,ild, rs1,rs2,rsu, exv,exrd,exd, lv,lrd,ld | st,rr,f1,f2, we,wa,wd
        tv = '{1'b0,5'd0,1'b0, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0}; tbl.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd0,5'd0,2'b00, 1'b1,5'd3,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0,1'b0, 1'b1,5'd3,32'hDEADBEEF}; tbl.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd3,5'd3,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b1, 1'b0,5'd3,32'hDEADBEEF}; tbl.push_back(tv);
        tv = '{1'b1,5'd7,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd3,32'hDEADBEEF}; tbl.push_back(tv);
        tv = '{1'b1,5'd8,1'b0, 5'd0,5'd7,2'b10, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0, 1'b0,5'd3,32'hDEADBEEF}; tbl.push_back(tv);
        tv = '{1'b1,5'd8,1'b0, 5'd0,5'd7,2'b10, 1'b1,5'd4,32'h44, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0,1'b0, 1'b1,5'd4,32'h44}; tbl.push_back(tv);
        tv = '{1'b1,5'd8,1'b0, 5'd0,5'd7,2'b10, 1'b0,5'd0,32'h0, 1'b1,5'd7,32'h1234, 1'b1,1'b1,1'b0,1'b0, 1'b1,5'd7,32'h1234}; tbl.push_back(tv);
        tv = '{1'b1,5'd8,1'b0, 5'd0,5'd7,2'b10, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b1, 1'b0,5'd7,32'h1234}; tbl.push_back(tv);
        tv = '{1'b1,5'd10,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd7,32'h1234}; tbl.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd0,5'd0,2'b00, 1'b1,5'd9,32'h99, 1'b1,5'd10,32'hAA, 1'b1,1'b0,1'b0,1'b0, 1'b1,5'd9,32'h99}; tbl.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd9,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b1,5'd10,32'hAA, 1'b0,1'b1,1'b1,1'b0, 1'b1,5'd10,32'hAA}; tbl.push_back(tv);
        tv = '{1'b1,5'd0,1'b1, 5'd0,5'd0,2'b00, 1'b1,5'd0,32'h55, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd10,32'hAA}; tbl.push_back(tv);
        tv = '{1'b1,5'd0,1'b0, 5'd0,5'd0,2'b11, 1'b1,5'd0,32'h55, 1'b1,5'd0,32'h77, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd10,32'hAA}; tbl.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd0,5'd10,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd10,32'hAA}; tbl.push_back(tv);

        // Two loads fill the limit; a response frees a slot for the blocked third load.
        tv = '{1'b1,5'd11,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd10,32'hAA}; seq_max.push_back(tv);
        tv = '{1'b1,5'd12,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd10,32'hAA}; seq_max.push_back(tv);
        tv = '{1'b1,5'd13,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0, 1'b0,5'd10,32'hAA}; seq_max.push_back(tv);
        tv = '{1'b1,5'd13,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b1,5'd11,32'h1111, 1'b1,1'b1,1'b0,1'b0, 1'b1,5'd11,32'h1111}; seq_max.push_back(tv);
        tv = '{1'b1,5'd13,1'b1, 5'd11,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,1'b0, 1'b0,5'd11,32'h1111}; seq_max.push_back(tv);
        tv = '{1'b1,5'd14,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0, 1'b0,5'd11,32'h1111}; seq_max.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b1,5'd12,32'h2222, 1'b0,1'b1,1'b0,1'b0, 1'b1,5'd12,32'h2222}; seq_max.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b1,5'd13,32'h3333, 1'b0,1'b1,1'b0,1'b0, 1'b1,5'd13,32'h3333}; seq_max.push_back(tv);

        // Load to x5 left pending, then reset; afterwards busy and count must be clear.
        tv = '{1'b1,5'd5,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd13,32'h3333}; seq_rst.push_back(tv);
        tv = '{1'b0,5'd0,1'b0, 5'd5,5'd0,2'b01, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0, 1'b0,5'd13,32'h3333}; seq_rst.push_back(tv);
        tv = '{1'b1,5'd6,1'b1, 5'd5,5'd0,2'b01, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0}; seq_rst.push_back(tv);
        tv = '{1'b1,5'd7,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0}; seq_rst.push_back(tv);
        tv = '{1'b1,5'd8,1'b1, 5'd0,5'd0,2'b00, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0}; seq_rst.push_back(tv);

        @(negedge clk);
        #1;
        check_reset_state("reset0");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < seq_max.size(); i++) begin
            apply_stimulus(seq_max[i], $sformatf("max%0d", i));
        end

        for (int i = 0; i < 2; i++) begin
            apply_stimulus(seq_rst[i], $sformatf("rst%0d", i));
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_reset_state("reset1");
        @(negedge clk);
        rst_n   = 1'b1;
        last_wd = '0;
        for (int i = 2; i < seq_rst.size(); i++) begin
            apply_stimulus(seq_rst[i], $sformatf("rst%0d", i));
        end

        @(negedge clk);
        drive_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
